instr_mem_writer: RTL and testbench

Write-side companion to the cache-based instruction memory. It accepts 16-bit instruction-word writes from a loader or debug port, buffers them in a small FIFO, and commits each one to main instruction memory over an acknowledged write port. After each acknowledged write it updates the matching direct-mapped cache line (128 lines, write-through with write-allocate), so the fetch side never reads a stale word.

---
 rtl/instr_mem_writer_if.sv | 30 +++
 rtl/instr_mem_writer.sv | 142 ++++++++++++++
 tb/tb_instr_mem_writer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_writer_if.sv
// Write-request, main-memory and cache-update signals of the instruction memory writer.
// The slave modport is the writer's view; the master modport is the loader/memory side.
interface instr_mem_writer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;

    logic        cache_we;
    logic [6:0]  cache_index;
    logic [8:0]  cache_tag;
    logic [15:0] cache_wdata;

    modport master (
        output wr_valid, wr_addr, wr_data, mem_ack,
        input  wr_ready, mem_we, mem_addr, mem_wdata,
        input  cache_we, cache_index, cache_tag, cache_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_ack,
        output wr_ready, mem_we, mem_addr, mem_wdata,
        output cache_we, cache_index, cache_tag, cache_wdata
    );
endinterface

// File: rtl/instr_mem_writer.sv
// Buffers instruction-word writes in a small FIFO and commits each one to main memory,
// then to the matching direct-mapped cache line once memory has acknowledged it.
module instr_mem_writer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    instr_mem_writer_if.slave  bus,
    output logic               idle,
    output logic [CNT_W-1:0]   writes_done
);
    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StUpdate} state_e;

    state_e state_q, state_d;

    logic [15:0]      buf_addr [DEPTH];
    logic [15:0]      buf_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ready, push, pop;
    logic [15:0]      head_addr, head_data;

    logic             mem_we_q, mem_we_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [15:0]      mem_wdata_q, mem_wdata_d;
    logic             cache_we_q, cache_we_d;
    logic [6:0]       cache_index_q, cache_index_d;
    logic [8:0]       cache_tag_q, cache_tag_d;
    logic [15:0]      cache_wdata_q, cache_wdata_d;
    logic [CNT_W-1:0] done_q, done_d;

    // Ready depends only on the registered count, so a pop never frees a slot same-cycle.
    assign ready     = (count_q < FULL);
    assign push      = bus.wr_valid && ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign head_addr = buf_addr[rd_ptr_q];
    assign head_data = buf_data[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr_q] <= bus.wr_addr;
            buf_data[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cache_we_d    = cache_we_q;
        cache_index_d = cache_index_q;
        cache_tag_d   = cache_tag_q;
        cache_wdata_d = cache_wdata_q;
        done_d        = done_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d       = StWrite;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = head_addr;
                    mem_wdata_d   = head_data;
                    cache_index_d = head_addr[6:0];
                    cache_tag_d   = head_addr[15:7];
                    cache_wdata_d = head_data;
                end
            end
            StWrite: begin
                // Memory must accept the word before the cache line is touched.
                if (bus.mem_ack) begin
                    state_d    = StUpdate;
                    mem_we_d   = 1'b0;
                    cache_we_d = 1'b1;
                end
            end
            StUpdate: begin
                state_d    = StIdle;
                cache_we_d = 1'b0;
                done_d     = done_q + CNT_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cache_we_q    <= 1'b0;
            cache_index_q <= '0;
            cache_tag_q   <= '0;
            cache_wdata_q <= '0;
            done_q        <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cache_we_q    <= cache_we_d;
            cache_index_q <= cache_index_d;
            cache_tag_q   <= cache_tag_d;
            cache_wdata_q <= cache_wdata_d;
            done_q        <= done_d;
        end
    end

    assign bus.wr_ready    = ready;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.cache_we    = cache_we_q;
    assign bus.cache_index = cache_index_q;
    assign bus.cache_tag   = cache_tag_q;
    assign bus.cache_wdata = cache_wdata_q;
    assign idle            = (state_q == StIdle) && (count_q == '0);
    assign writes_done     = done_q;
endmodule

// File: tb/tb_instr_mem_writer.sv
// Directed bench for instr_mem_writer with an in-order reference queue for memory and
// cache traffic, plus a random-delay ack responder for the long wrap run.
module tb_instr_mem_writer;
    logic       clk;
    logic       reset;
    logic       idle;
    logic [7:0] writes_done;
    logic       ack_dir;
    logic       ack_auto;
    logic       auto_ack;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cache_pulses = 0;

    logic [31:0] mem_q[$];
    logic [31:0] cache_q[$];

    instr_mem_writer_if bus();

    instr_mem_writer #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .idle        (idle),
        .writes_done (writes_done)
    );

    assign bus.mem_ack = ack_dir | ack_auto;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expct);
        total_cnt++;
        assert (obs === expct) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expct);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        int guard = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        while (!bus.wr_ready && guard < 200) begin
            step();
            guard++;
        end
        chk("push_ready", 32'(bus.wr_ready), 32'd1);
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_mem_we();
        int guard = 0;
        while (!bus.mem_we && guard < 50) begin
            step();
            guard++;
        end
        chk("mem_we_wait", 32'(bus.mem_we), 32'd1);
    endtask

    // Reference model: pushes enter both queues, memory then cache must drain them in order.
    initial begin
        logic        mem_we_prev;
        logic [31:0] e;
        mem_we_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_q.delete();
                cache_q.delete();
            end else begin
                if (bus.mem_we && !mem_we_prev) begin
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected", 32'(bus.mem_we), 32'd0);
                    end else begin
                        e = mem_q.pop_front();
                        chk("mem_addr", 32'(bus.mem_addr), 32'(e[31:16]));
                        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e[15:0]));
                    end
                end
                if (bus.cache_we) begin
                    cache_pulses++;
                    if (cache_q.size() == 0) begin
                        chk("cache_unexpected", 32'(bus.cache_we), 32'd0);
                    end else begin
                        e = cache_q.pop_front();
                        chk("cache_index", 32'(bus.cache_index), 32'(e[22:16]));
                        chk("cache_tag", 32'(bus.cache_tag), 32'(e[31:23]));
                        chk("cache_wdata", 32'(bus.cache_wdata), 32'(e[15:0]));
                    end
                end
                if (bus.wr_valid && bus.wr_ready) begin
                    mem_q.push_back({bus.wr_addr, bus.wr_data});
                    cache_q.push_back({bus.wr_addr, bus.wr_data});
                end
            end
            mem_we_prev = bus.mem_we;
        end
    end

    initial begin
        int unsigned ack_wait;
        ack_auto = 1'b0;
        ack_wait = 0;
        forever begin
            @(negedge clk);
            if (!auto_ack || reset) begin
                ack_auto = 1'b0;
            end else if (ack_auto) begin
                ack_auto = 1'b0;
                ack_wait = $urandom_range(0, 3);
            end else if (bus.mem_we) begin
                if (ack_wait == 0) ack_auto = 1'b1;
                else ack_wait--;
            end
        end
    end

    initial begin
        int base;
        int hi;
        int seen;
        int guard;
        reset        = 1'b1;
        ack_dir      = 1'b0;
        auto_ack     = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        // Reset state
        step();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_cache_we", 32'(bus.cache_we), 32'd0);
        chk("rst_cache_index", 32'(bus.cache_index), 32'd0);
        chk("rst_done", 32'(writes_done), 32'd0);
        reset = 1'b0;

        // Single write with ack held high
        ack_dir = 1'b1;
        push(16'h0285, 16'hA9FF);
        chk("t1_no_we_yet", 32'(bus.mem_we), 32'd0);
        step();
        chk("t1_mem_we", 32'(bus.mem_we), 32'd1);
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0285);
        chk("t1_mem_wdata", 32'(bus.mem_wdata), 32'hA9FF);
        step();
        chk("t1_mem_we_low", 32'(bus.mem_we), 32'd0);
        chk("t1_cache_we", 32'(bus.cache_we), 32'd1);
        chk("t1_index", 32'(bus.cache_index), 32'h05);
        chk("t1_tag", 32'(bus.cache_tag), 32'h005);
        chk("t1_cwdata", 32'(bus.cache_wdata), 32'hA9FF);
        step();
        ack_dir = 1'b0;
        chk("t1_cache_we_low", 32'(bus.cache_we), 32'd0);
        chk("t1_done", 32'(writes_done), 32'd1);
        chk("t1_idle", 32'(idle), 32'd1);

        // Fill to full while memory stalls
        base = cache_pulses;
        for (int i = 0; i < 5; i++) begin
            push(16'(i), 16'(16'h1000 + i));
            if (i == 3) chk("t2_ready_before_5th", 32'(bus.wr_ready), 32'd1);
        end
        chk("t2_ready_full", 32'(bus.wr_ready), 32'd0);
        chk("t2_mem_we", 32'(bus.mem_we), 32'd1);
        chk("t2_mem_addr", 32'(bus.mem_addr), 32'h0000);
        for (int i = 0; i < 3; i++) step();
        chk("t2_stall_addr", 32'(bus.mem_addr), 32'h0000);
        chk("t2_stall_we", 32'(bus.mem_we), 32'd1);
        chk("t2_stall_ready", 32'(bus.wr_ready), 32'd0);
        chk("t2_not_idle", 32'(idle), 32'd0);

        // Release one ack at a time; order must follow acceptance
        for (int k = 0; k < 5; k++) begin
            wait_mem_we();
            if (k == 1) chk("t3_ready_back", 32'(bus.wr_ready), 32'd1);
            chk("t3_order", 32'(bus.mem_addr), 32'(k));
            ack_dir = 1'b1;
            step();
            ack_dir = 1'b0;
            chk("t3_cache_we", 32'(bus.cache_we), 32'd1);
            chk("t3_cache_index", 32'(bus.cache_index), 32'(k));
            step();
            chk("t3_cache_we_1cyc", 32'(bus.cache_we), 32'd0);
        end
        chk("t3_done", 32'(writes_done), 32'd6);
        chk("t3_idle", 32'(idle), 32'd1);
        chk("t3_pulses", 32'(cache_pulses - base), 32'd5);

        // Stray ack in IDLE, then a 7-cycle WRITE
        ack_dir = 1'b1;
        step();
        step();
        ack_dir = 1'b0;
        chk("t4_stray_idle", 32'(idle), 32'd1);
        chk("t4_stray_we", 32'(bus.mem_we), 32'd0);
        chk("t4_stray_cache", 32'(bus.cache_we), 32'd0);
        chk("t4_stray_done", 32'(writes_done), 32'd6);
        base = cache_pulses;
        push(16'h1234, 16'hBEEF);
        step();
        hi = bus.mem_we ? 1 : 0;
        for (int j = 1; j < 7; j++) begin
            step();
            if (bus.mem_we) hi++;
        end
        ack_dir = 1'b1;
        step();
        ack_dir = 1'b0;
        chk("t4_we_cycles", 32'(hi), 32'd7);
        chk("t4_we_low", 32'(bus.mem_we), 32'd0);
        chk("t4_cache_we", 32'(bus.cache_we), 32'd1);
        for (int j = 0; j < 4; j++) step();
        chk("t4_one_pulse", 32'(cache_pulses - base), 32'd1);
        chk("t4_done", 32'(writes_done), 32'd7);

        // Async reset with one write in flight and three buffered
        for (int i = 0; i < 4; i++) push(16'(16'h2000 + i), 16'(16'h3000 + i));
        chk("t5_inflight", 32'(bus.mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_we_drop", 32'(bus.mem_we), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);
        chk("t5_done", 32'(writes_done), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (bus.mem_we) seen++;
        end
        chk("t5_no_replay", 32'(seen), 32'd0);
        chk("t5_idle_after", 32'(idle), 32'd1);

        // Async reset during UPDATE
        ack_dir = 1'b1;
        push(16'h00FF, 16'h1111);
        step();
        step();
        ack_dir = 1'b0;
        chk("t5_update", 32'(bus.cache_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_cache_drop", 32'(bus.cache_we), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        step();
        step();
        chk("t5_done_after", 32'(writes_done), 32'd0);

        // 260 writes with random ack delay: counter wraps to 4, pointers wrap many times
        base = cache_pulses;
        auto_ack = 1'b1;
        for (int i = 0; i < 260; i++) begin
            push(16'(i * 16'h0101 ^ 16'h5A3C), 16'(i * 3 + 16'h7000));
        end
        guard = 0;
        while (!idle && guard < 100) begin
            step();
            guard++;
        end
        step();
        chk("t6_idle", 32'(idle), 32'd1);
        chk("t6_done_wrap", 32'(writes_done), 32'd4);
        chk("t6_pulses", 32'(cache_pulses - base), 32'd260);
        chk("t6_mem_q_empty", 32'(mem_q.size()), 32'd0);
        chk("t6_cache_q_empty", 32'(cache_q.size()), 32'd0);
        auto_ack = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
